// File: rtl/mic_pdm_capture_pkg.sv
// ============================================================================
//  Module      : mic_pkg
//  Description : Shared types and constants for the PDM microphone capture path.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int c_CLK_DIV_DEF = 2;
    localparam int c_WORD_W_DEF  = 8;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mic_pdm_capture_clk_div.sv
// ============================================================================
//  Module      : mic_clk_div
//  Description : PDM clock divider; produces mic_clk and a one-cycle sample
//                tick just before each mic_clk falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mic_clk_div
    import mic_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_mic_clk,
    output logic o_tick
);

    localparam int c_DIV_W = clog2(CLK_DIV);

    logic [c_DIV_W-1:0] r_div;
    logic               r_mic_clk;
    logic               w_wrap;

    assign w_wrap = (r_div == c_DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_mic_clk <= 1'b0;
        end else if (!i_en || i_clr) begin
            r_div     <= '0;
            r_mic_clk <= 1'b0;
        end else if (w_wrap) begin
            r_div     <= '0;
            r_mic_clk <= ~r_mic_clk;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // The tick ignores i_clr so a bit landing on the final RUN cycle is kept.
    assign o_tick    = i_en & w_wrap & r_mic_clk;
    assign o_mic_clk = r_mic_clk;

endmodule

`default_nettype wire

// File: rtl/mic_pdm_capture.sv
// ============================================================================
//  Module      : mic_pdm_capture
//  Description : PDM mic front end: clocks the mic, packs bits MSB-first into
//                words and writes them to a fifo. Optional MIC_SYNC_EN adds a
//                2-flop input synchronizer with a matching tick delay.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mic_pdm_capture
    import mic_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEF,
    parameter int WORD_W  = c_WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mic_data,
    input  logic              full,
    output logic              mic_clk,
    output logic              wr,
    output logic [WORD_W-1:0] data_out,
    output logic              overflow,
    output logic              busy
);

    localparam int c_BIT_W = clog2(WORD_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_run;
    logic                w_tick;
    logic                w_last;
    logic                w_samp_tick;
    logic                w_samp_last;
    logic                w_samp_data;
    logic [c_BIT_W-1:0]  r_bit;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   w_word;
    logic                r_wr;
    logic [WORD_W-1:0]   r_data;
    logic                r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = RUN;
            end
            RUN: begin
                w_run = 1'b1;
                if (!enable) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    mic_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_run),
        .i_clr     (~enable),
        .o_mic_clk (mic_clk),
        .o_tick    (w_tick)
    );

    // Bit position is tracked on the undelayed tick so leaving RUN always
    // restarts at bit 0, even with ticks still travelling down the delay line.
    assign w_last = (r_bit == c_BIT_W'(WORD_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit <= '0;
        end else if (!w_run) begin
            r_bit <= '0;
        end else if (w_tick) begin
            r_bit <= w_last ? '0 : r_bit + 1'b1;
        end
    end

`ifdef MIC_SYNC_EN
    logic [1:0] r_sync;
    logic [1:0] r_tick_dly;
    logic [1:0] r_last_dly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync     <= '0;
            r_tick_dly <= '0;
            r_last_dly <= '0;
        end else begin
            r_sync     <= {r_sync[0], mic_data};
            r_tick_dly <= {r_tick_dly[0], w_tick};
            r_last_dly <= {r_last_dly[0], w_tick & w_last};
        end
    end

    assign w_samp_tick = r_tick_dly[1];
    assign w_samp_last = r_last_dly[1];
    assign w_samp_data = r_sync[1];
`else
    assign w_samp_tick = w_tick;
    assign w_samp_last = w_tick & w_last;
    assign w_samp_data = mic_data;
`endif

    assign w_word = {r_shift[WORD_W-2:0], w_samp_data};

    // Stale bits left by an aborted word are shifted out by the next full word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (w_samp_tick) begin
            r_shift <= w_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr   <= 1'b0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (w_samp_last) begin
                if (full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wr   <= 1'b1;
                    r_data <= w_word;
                end
            end
        end
    end

    assign wr       = r_wr;
    assign data_out = r_data;
    assign overflow = r_ovf;
    assign busy     = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_mic_pdm_capture.sv
// ============================================================================
//  Module      : tb_mic_pdm_capture
//  Description : Directed table-driven bench for mic_pdm_capture (CLK_DIV=2,
//                WORD_W=8), with hand-written abort and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mic_pdm_capture;

    localparam int CLK_DIV  = 2;
    localparam int WORD_W   = 8;
    localparam int TICK_CYC = 2 * CLK_DIV;
    localparam int WORD_CYC = TICK_CYC * WORD_W;
`ifdef MIC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       mic_data = 1'b0;
    logic       full = 1'b0;
    logic       mic_clk;
    logic       wr;
    logic [7:0] data_out;
    logic       overflow;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] word;
        logic       full;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [NVEC];

    mic_pdm_capture #(
        .CLK_DIV (CLK_DIV),
        .WORD_W  (WORD_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mic_data (mic_data),
        .full     (full),
        .mic_clk  (mic_clk),
        .wr       (wr),
        .data_out (data_out),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one fresh word from RUN cycle 0; optionally drops enable at stop_at.
    task automatic run_fresh(input logic [7:0] pat, input int ncyc, input int stop_at);
        for (int g = 0; g < ncyc; g++) begin
            mic_data = (g < WORD_CYC) ? pat[3'(7 - g / TICK_CYC)] : 1'b0;
            if (g == stop_at) enable = 1'b0;
            check("fresh_mic_clk", 32'(mic_clk), (g / CLK_DIV) % 2);
            if (g == WORD_CYC - 1 + LAT) begin
                check("fresh_wr", 32'(wr), 1);
                check("fresh_data", 32'(data_out), 32'(pat));
            end else begin
                check("fresh_wr_idle", 32'(wr), 0);
            end
            step();
        end
    endtask

    initial begin
        vecs[0] = '{8'hB2, 1'b0, 1'b1, 8'hB2, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1};
        vecs[6] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b1};

        // Reset state
        repeat (3) step();
        check("rst_wr", 32'(wr), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mic_clk", 32'(mic_clk), 0);
        reset = 1'b1;
        step();
        step();
        check("idle_busy", 32'(busy), 0);
        check("idle_wr", 32'(wr), 0);

        // Continuous capture of the vector table
        enable = 1'b1;
        step();
        for (int g = 0; g <= NVEC * WORD_CYC + LAT; g++) begin
            int w;
            int c;
            int f;
            int k;
            w = g / WORD_CYC;
            c = g % WORD_CYC;
            mic_data = (w < NVEC) ? vecs[w].word[3'(7 - c / TICK_CYC)] : 1'b0;
            full = 1'b0;
            f = g - (LAT - 1);
            if (f >= 0 && f % WORD_CYC == WORD_CYC - 1 && f / WORD_CYC < NVEC)
                full = vecs[f / WORD_CYC].full;
            check("run_mic_clk", 32'(mic_clk), (g / CLK_DIV) % 2);
            check("run_busy", 32'(busy), 1);
            k = g - LAT;
            if (k >= 0 && k % WORD_CYC == WORD_CYC - 1 && k / WORD_CYC < NVEC) begin
                check("vec_wr", 32'(wr), 32'(vecs[k / WORD_CYC].exp_wr));
                check("vec_data", 32'(data_out), 32'(vecs[k / WORD_CYC].exp_data));
                check("vec_ovf", 32'(overflow), 32'(vecs[k / WORD_CYC].exp_ovf));
            end else begin
                check("run_wr_idle", 32'(wr), 0);
            end
            step();
        end
        full = 1'b0;

        // Stop mid-word: no write, overflow retained
        enable = 1'b0;
        step();
        check("stop_busy", 32'(busy), 0);
        check("stop_mic_clk", 32'(mic_clk), 0);
        repeat (10) begin
            check("stop_wr", 32'(wr), 0);
            step();
        end
        check("stop_ovf", 32'(overflow), 1);

        // Abort after 4 bits, then a fresh 0x5A word
        enable = 1'b1;
        step();
        run_fresh(8'hFF, 4 * TICK_CYC + 1, 4 * TICK_CYC);
        check("abort_busy", 32'(busy), 0);
        check("abort_mic_clk", 32'(mic_clk), 0);
        for (int i = 0; i < 40; i++) begin
            check("abort_wr", 32'(wr), 0);
            step();
        end
        check("abort_data_held", 32'(data_out), 32'h81);
        enable = 1'b1;
        step();
        run_fresh(8'h5A, WORD_CYC + LAT + 2, -1);
        check("refresh_ovf", 32'(overflow), 1);

        // Async reset mid-word with mic_clk high
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        run_fresh(8'hFF, 5 * TICK_CYC + 2, -1);
        check("pre_rst_mic_clk", 32'(mic_clk), 1);
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        enable = 1'b0;
        #1;
        check("arst_wr", 32'(wr), 0);
        check("arst_data", 32'(data_out), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_mic_clk", 32'(mic_clk), 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("post_rst_wr", 32'(wr), 0);
            check("post_rst_busy", 32'(busy), 0);
            check("post_rst_mic_clk", 32'(mic_clk), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
